// File: rtl/bookkeeping_directory_client_if.sv
// Bundle of the three handshake channels around the bookkeeping directory
// client: command in from the protocol engine, response back to it, and the
// put/get pair towards the directory.
//   master : the client itself
//   slave  : its environment (protocol engine plus directory)
interface bookkeeping_directory_client_if #(
    parameter int INDEX_WIDTH    = 12,
    parameter int TAG_WIDTH      = 18,
    parameter int MSI_STATE_SIZE = 2
);
    localparam int ROW_WIDTH   = MSI_STATE_SIZE + TAG_WIDTH;
    localparam int REQ_WIDTH   = INDEX_WIDTH + 1 + ROW_WIDTH + 2;
    localparam int ENTRY_WIDTH = 4 * ROW_WIDTH;

    // command channel
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [INDEX_WIDTH-1:0] cmd_idx;
    logic                   cmd_core_id;
    logic                   cmd_cache_type;
    logic [ROW_WIDTH-1:0]   cmd_row;

    // response channel
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ENTRY_WIDTH-1:0] rsp_entry;
    logic [ROW_WIDTH-1:0]   rsp_row;

    // directory put/get channels
    logic                   dir_put_valid;
    logic                   dir_put_ready;
    logic [REQ_WIDTH-1:0]   dir_put_request;
    logic                   dir_get_valid;
    logic                   dir_get_ready;
    logic [ENTRY_WIDTH-1:0] dir_get_response;

    modport master (
        input  cmd_valid, cmd_op, cmd_idx, cmd_core_id, cmd_cache_type, cmd_row,
        output cmd_ready,
        output rsp_valid, rsp_entry, rsp_row,
        input  rsp_ready,
        output dir_put_valid, dir_put_request,
        input  dir_put_ready,
        output dir_get_valid,
        input  dir_get_ready, dir_get_response
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_idx, cmd_core_id, cmd_cache_type, cmd_row,
        input  cmd_ready,
        input  rsp_valid, rsp_entry, rsp_row,
        output rsp_ready,
        input  dir_put_valid, dir_put_request,
        output dir_put_ready,
        input  dir_get_valid,
        output dir_get_ready, dir_get_response
    );
endinterface

// File: rtl/bookkeeping_directory_client.sv
// Initiator-side controller for the bookkeeping directory put/get port.
// Takes one READ / WRITE / READ_WRITE command at a time, turns it into one or
// two directory puts plus at most one get, and returns a single registered
// response carrying the entry read and the row belonging to the requester.
// Every output is a flop, so there is no combinational path from either
// directory ready back to a directory valid.
module bookkeeping_directory_client #(
    parameter int INDEX_WIDTH    = 12,
    parameter int TAG_WIDTH      = 18,
    parameter int MSI_STATE_SIZE = 2
) (
    input  logic CLK,
    input  logic RST,
    bookkeeping_directory_client_if.master bus
);
    localparam int ROW_WIDTH   = MSI_STATE_SIZE + TAG_WIDTH;
    localparam int REQ_WIDTH   = INDEX_WIDTH + 1 + ROW_WIDTH + 2;
    localparam int ENTRY_WIDTH = 4 * ROW_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        PUT_RD,
        GET,
        PUT_WR,
        RSP
    } state_t;

    // Encoding 3 is reserved and handled exactly like READ.
    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_WRITE      = 2'd1,
        OP_READ_WRITE = 2'd2,
        OP_RESERVED   = 2'd3
    } op_t;

    state_t                 state;

    // captured command
    op_t                    op_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic                   core_q;
    logic                   cache_q;
    logic [ROW_WIDTH-1:0]   row_q;

    // registered outputs
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic [ENTRY_WIDTH-1:0] rsp_entry_q;
    logic [ROW_WIDTH-1:0]   rsp_row_q;
    logic                   put_valid_q;
    logic [REQ_WIDTH-1:0]   put_req_q;
    logic                   get_valid_q;

    op_t                    cmd_op_in;

    assign cmd_op_in = op_t'(bus.cmd_op);

    // Directory request layout, MSB first: {idx, write_valid, row, core_id, cache_type}.
    function automatic logic [REQ_WIDTH-1:0] pack_req(
        input logic [INDEX_WIDTH-1:0] idx,
        input logic                   write_valid,
        input logic [ROW_WIDTH-1:0]   row,
        input logic                   core_id,
        input logic                   cache_type
    );
        return {idx, write_valid, row, core_id, cache_type};
    endfunction

    // Entry layout, MSB first: {imem0, dmem0, imem1, dmem1}.
    function automatic logic [ROW_WIDTH-1:0] select_row(
        input logic [ENTRY_WIDTH-1:0] entry,
        input logic                   core_id,
        input logic                   cache_type
    );
        logic [ROW_WIDTH-1:0] row;
        case ({core_id, cache_type})
            2'b00:   row = entry[4*ROW_WIDTH-1 : 3*ROW_WIDTH];
            2'b01:   row = entry[3*ROW_WIDTH-1 : 2*ROW_WIDTH];
            2'b10:   row = entry[2*ROW_WIDTH-1 : ROW_WIDTH];
            default: row = entry[ROW_WIDTH-1 : 0];
        endcase
        return row;
    endfunction

    // Command sequencer: state, captured command and all outputs in one register stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            op_q        <= OP_READ;
            idx_q       <= '0;
            core_q      <= 1'b0;
            cache_q     <= 1'b0;
            row_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_entry_q <= '0;
            rsp_row_q   <= '0;
            put_valid_q <= 1'b0;
            put_req_q   <= '0;
            get_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready comes up on the first clock after reset release.
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op_in;
                        idx_q       <= bus.cmd_idx;
                        core_q      <= bus.cmd_core_id;
                        cache_q     <= bus.cmd_cache_type;
                        row_q       <= bus.cmd_row;
                        // WRITE responses carry zeros; reads overwrite these in GET.
                        rsp_entry_q <= '0;
                        rsp_row_q   <= '0;
                        put_valid_q <= 1'b1;
                        if (cmd_op_in == OP_WRITE) begin
                            put_req_q <= pack_req(bus.cmd_idx, 1'b1, bus.cmd_row,
                                                  bus.cmd_core_id, bus.cmd_cache_type);
                            state     <= PUT_WR;
                        end else begin
                            put_req_q <= pack_req(bus.cmd_idx, 1'b0, '0,
                                                  bus.cmd_core_id, bus.cmd_cache_type);
                            state     <= PUT_RD;
                        end
                    end
                end

                PUT_RD: begin
                    if (bus.dir_put_ready) begin
                        put_valid_q <= 1'b0;
                        get_valid_q <= 1'b1;
                        state       <= GET;
                    end
                end

                GET: begin
                    if (bus.dir_get_ready) begin
                        get_valid_q <= 1'b0;
                        rsp_entry_q <= bus.dir_get_response;
                        rsp_row_q   <= select_row(bus.dir_get_response, core_q, cache_q);
                        if (op_q == OP_READ_WRITE) begin
                            // Write-back put follows the read with no idle cycle.
                            put_valid_q <= 1'b1;
                            put_req_q   <= pack_req(idx_q, 1'b1, row_q, core_q, cache_q);
                            state       <= PUT_WR;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            state       <= RSP;
                        end
                    end
                end

                PUT_WR: begin
                    if (bus.dir_put_ready) begin
                        put_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RSP;
                    end
                end

                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    put_valid_q <= 1'b0;
                    get_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready       = cmd_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_entry       = rsp_entry_q;
    assign bus.rsp_row         = rsp_row_q;
    assign bus.dir_put_valid   = put_valid_q;
    assign bus.dir_put_request = put_req_q;
    assign bus.dir_get_valid   = get_valid_q;
endmodule

// File: tb/tb_bookkeeping_directory_client.sv
// Bench for bookkeeping_directory_client: a behavioural directory answers the
// put/get port with configurable or random stalls, and a separate reference
// memory predicts every response from the command semantics.
module tb_bookkeeping_directory_client;
    localparam int IW  = 12;
    localparam int ROW = 20;
    localparam int REQ = IW + 1 + ROW + 2;
    localparam int ENT = 4 * ROW;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    bookkeeping_directory_client_if #(.INDEX_WIDTH(IW), .TAG_WIDTH(18), .MSI_STATE_SIZE(2)) bus ();

    bookkeeping_directory_client #(.INDEX_WIDTH(IW), .TAG_WIDTH(18), .MSI_STATE_SIZE(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [ENT-1:0] dir_mem [4096];
    logic [ENT-1:0] ref_mem [4096];

    // directory behaviour controls and observations
    bit             rand_rdy      = 1'b0;
    int             put_stall_fix = 0;
    int             get_stall_fix = 0;
    int             put_wait      = 0;
    int             get_wait      = 0;
    int             put_stall     = 0;
    int             get_stall     = 0;
    int             stall_sum     = 0;
    int             trace         = 0;
    bit             pending       = 1'b0;
    logic [IW-1:0]  pend_idx;
    logic [REQ-1:0] prev_put_req;
    logic [REQ-1:0] last_rd_req;
    logic [REQ-1:0] last_wr_req;

    function automatic logic [ROW-1:0] get_row(input logic [ENT-1:0] e, input int sel);
        logic [ENT-1:0] t;
        t = e >> ((3 - sel) * ROW);
        return t[ROW-1:0];
    endfunction

    function automatic logic [ENT-1:0] put_row(input logic [ENT-1:0] e, input int sel,
                                               input logic [ROW-1:0] r);
        logic [ENT-1:0] mask;
        logic [ENT-1:0] val;
        mask = {{(ENT-ROW){1'b0}}, {ROW{1'b1}}} << ((3 - sel) * ROW);
        val  = {{(ENT-ROW){1'b0}}, r} << ((3 - sel) * ROW);
        return (e & ~mask) | val;
    endfunction

    task automatic end_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic preload(input logic [IW-1:0] idx, input logic [ENT-1:0] e);
        dir_mem[idx] = e;
        ref_mem[idx] = e;
    endtask

    // Behavioural directory: decides readies at each negedge, so every
    // handshake it grants completes at the following posedge.
    initial begin : directory
        logic [95:0]    junk;
        logic [REQ-1:0] req;
        logic [IW-1:0]  ridx;
        bus.dir_put_ready    = 1'b0;
        bus.dir_get_ready    = 1'b0;
        bus.dir_get_response = '0;
        forever begin
            @(negedge CLK);
            junk = {$urandom(), $urandom(), $urandom()};
            if (RST) begin
                pending = 1'b0;  put_wait = 0;  get_wait = 0;
                bus.dir_put_ready = 1'b0;  bus.dir_get_ready = 1'b0;
                continue;
            end
            // put channel
            if (put_wait > 0) begin
                total++;
                if (bus.dir_put_valid !== 1'b1 || bus.dir_put_request !== prev_put_req) begin
                    bad++;
                    $display("FAIL put_stable: valid=%b req=%h, required valid=1 req=%h",
                             bus.dir_put_valid, bus.dir_put_request, prev_put_req);
                end
            end
            if (bus.dir_put_valid === 1'b1) begin
                if (put_wait == 0) put_stall = rand_rdy ? int'($urandom_range(0, 3)) : put_stall_fix;
                prev_put_req = bus.dir_put_request;
                if (put_wait >= put_stall) begin
                    bus.dir_put_ready = 1'b1;
                    stall_sum += put_stall;
                    put_wait = 0;
                    req  = bus.dir_put_request;
                    ridx = req[REQ-1 -: IW];
                    if (req[ROW+2]) begin
                        dir_mem[ridx] = put_row(dir_mem[ridx], int'(req[1:0]), req[ROW+1:2]);
                        last_wr_req   = req;
                        trace         = trace * 4 + 3;
                    end else begin
                        pending     = 1'b1;
                        pend_idx    = ridx;
                        last_rd_req = req;
                        trace       = trace * 4 + 1;
                    end
                end else begin
                    bus.dir_put_ready = 1'b0;
                    put_wait++;
                end
            end else begin
                bus.dir_put_ready = 1'b0;
                put_wait = 0;
            end
            // get channel
            if (get_wait > 0) begin
                total++;
                if (bus.dir_get_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL get_stable: valid=%b, required 1", bus.dir_get_valid);
                end
            end
            if (bus.dir_get_valid === 1'b1) begin
                total++;
                if (!pending) begin
                    bad++;
                    $display("FAIL get_without_read_put: get_valid=1, required 0");
                end
                if (get_wait == 0) get_stall = rand_rdy ? int'($urandom_range(0, 3)) : get_stall_fix;
                if (get_wait >= get_stall) begin
                    bus.dir_get_ready    = 1'b1;
                    bus.dir_get_response = dir_mem[pend_idx];
                    stall_sum += get_stall;
                    get_wait = 0;
                    pending  = 1'b0;
                    trace    = trace * 4 + 2;
                end else begin
                    bus.dir_get_ready    = 1'b0;
                    bus.dir_get_response = junk[ENT-1:0];
                    get_wait++;
                end
            end else begin
                bus.dir_get_ready    = 1'b0;
                bus.dir_get_response = junk[ENT-1:0];
                get_wait = 0;
            end
        end
    end

    // Drives one command and its response handshake; called and returns at a negedge.
    // lat = posedges from the accept edge to the earliest possible response handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [IW-1:0] idx, input logic core,
                          input logic cache, input logic [ROW-1:0] row, input int hold,
                          output logic [ENT-1:0] entry, output logic [ROW-1:0] rrow,
                          output int lat, output int viol, output bit timeout);
        int n;
        viol = 0;  timeout = 1'b0;  lat = 0;  entry = '0;  rrow = '0;
        n = 0;
        while (bus.cmd_ready !== 1'b1) begin
            @(negedge CLK);
            n++;
            if (n > 50) begin timeout = 1'b1; return; end
        end
        trace = 0;  stall_sum = 0;
        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = op;
        bus.cmd_idx        = idx;
        bus.cmd_core_id    = core;
        bus.cmd_cache_type = cache;
        bus.cmd_row        = row;
        @(negedge CLK);
        bus.cmd_valid      = 1'b0;
        bus.cmd_op         = 2'($urandom());
        bus.cmd_idx        = IW'($urandom());
        bus.cmd_core_id    = 1'($urandom());
        bus.cmd_cache_type = 1'($urandom());
        bus.cmd_row        = ROW'($urandom());
        n = 0;
        while (bus.rsp_valid !== 1'b1) begin
            if (bus.cmd_ready !== 1'b0) viol++;
            @(negedge CLK);
            n++;
            if (n > 200) begin timeout = 1'b1; return; end
        end
        lat   = n + 1;
        entry = bus.rsp_entry;
        rrow  = bus.rsp_row;
        for (int h = 0; h < hold; h++) begin
            if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
                bus.rsp_entry !== entry || bus.rsp_row !== rrow) viol++;
            @(negedge CLK);
        end
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
            bus.rsp_entry !== entry || bus.rsp_row !== rrow) viol++;
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) viol++;
    endtask

    // One command end to end, judged against the reference memory.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [IW-1:0] idx,
                           input logic core, input logic cache, input logic [ROW-1:0] row,
                           input int hold, output logic [ENT-1:0] entry,
                           output logic [ROW-1:0] rrow, output int lat);
        logic [ENT-1:0] exp_entry;
        logic [ROW-1:0] exp_row;
        logic [REQ-1:0] exp_rd_req;
        logic [REQ-1:0] exp_wr_req;
        int             exp_trace;
        int             base;
        int             sel;
        int             viol;
        bit             timeout;
        sel        = int'(core) * 2 + int'(cache);
        exp_rd_req = {idx, 1'b0, {ROW{1'b0}}, core, cache};
        exp_wr_req = {idx, 1'b1, row, core, cache};
        if (op == 2'd1) begin
            exp_entry = '0;  exp_row = '0;  exp_trace = 3;  base = 2;
            ref_mem[idx] = put_row(ref_mem[idx], sel, row);
        end else if (op == 2'd2) begin
            exp_entry = ref_mem[idx];  exp_row = get_row(ref_mem[idx], sel);
            exp_trace = 27;  base = 4;
            ref_mem[idx] = put_row(ref_mem[idx], sel, row);
        end else begin
            exp_entry = ref_mem[idx];  exp_row = get_row(ref_mem[idx], sel);
            exp_trace = 6;  base = 3;
        end
        last_rd_req = '0;
        last_wr_req = '0;
        do_cmd(op, idx, core, cache, row, hold, entry, rrow, lat, viol, timeout);
        total++;
        if (timeout) begin
            bad++;
            $display("FAIL %s timeout: no handshake within budget, required completion", name);
            end_run();
        end
        total++;
        if (entry !== exp_entry) begin
            bad++;
            $display("FAIL %s rsp_entry: got %h, required %h", name, entry, exp_entry);
        end
        total++;
        if (rrow !== exp_row) begin
            bad++;
            $display("FAIL %s rsp_row: got %h, required %h", name, rrow, exp_row);
        end
        total++;
        if (trace !== exp_trace) begin
            bad++;
            $display("FAIL %s dir_sequence: got code %0d, required %0d", name, trace, exp_trace);
        end
        total++;
        if (lat !== base + stall_sum) begin
            bad++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, base + stall_sum);
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL %s handshake_rules: got %0d violations, required 0", name, viol);
        end
        if (op != 2'd1) begin
            total++;
            if (last_rd_req !== exp_rd_req) begin
                bad++;
                $display("FAIL %s read_put_request: got %h, required %h", name, last_rd_req, exp_rd_req);
            end
        end
        if (op == 2'd1 || op == 2'd2) begin
            total++;
            if (last_wr_req !== exp_wr_req) begin
                bad++;
                $display("FAIL %s write_put_request: got %h, required %h", name, last_wr_req, exp_wr_req);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.cmd_valid = 1'b0;  bus.cmd_op = '0;  bus.cmd_idx = '0;
        bus.cmd_core_id = 1'b0;  bus.cmd_cache_type = 1'b0;  bus.cmd_row = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.dir_put_valid, bus.dir_get_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_controls: {cmd_ready,rsp_valid,put_valid,get_valid}=%b, required 0000",
                     {bus.cmd_ready, bus.rsp_valid, bus.dir_put_valid, bus.dir_get_valid});
        end
        total++;
        if (bus.rsp_entry !== '0 || bus.rsp_row !== '0) begin
            bad++;
            $display("FAIL reset_data: rsp_entry=%h rsp_row=%h, required 0", bus.rsp_entry, bus.rsp_row);
        end
        #1 RST = 1'b0;
        @(negedge CLK);
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: cmd_ready=%b, required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_read();
        logic [ENT-1:0] e;  logic [ROW-1:0] r;  int lat;
        preload(12'h123, {20'h1, 20'h2, 20'h3, 20'h4});
        run_cmd("read", 2'd0, 12'h123, 1'b1, 1'b1, 20'h55555, 0, e, r, lat);
        total++;
        if (r !== 20'h4 || e !== {20'h1, 20'h2, 20'h3, 20'h4} || lat !== 3) begin
            bad++;
            $display("FAIL read_directed: row=%h lat=%0d, required row=00004 lat=3", r, lat);
        end
    endtask

    task automatic test_write();
        logic [ENT-1:0] e;  logic [ROW-1:0] r;  int lat;
        run_cmd("write", 2'd1, 12'h7FF, 1'b0, 1'b0, 20'hABCDE, 0, e, r, lat);
        total++;
        if (e !== '0 || r !== '0 || lat !== 2) begin
            bad++;
            $display("FAIL write_directed: entry=%h row=%h lat=%0d, required 0 0 2", e, r, lat);
        end
        run_cmd("write_readback", 2'd0, 12'h7FF, 1'b0, 1'b0, 20'h0, 0, e, r, lat);
        total++;
        if (r !== 20'hABCDE) begin
            bad++;
            $display("FAIL write_readback_row: got %h, required abcde", r);
        end
    endtask

    task automatic test_read_write();
        logic [ENT-1:0] old;  logic [ENT-1:0] e;  logic [ROW-1:0] r;  int lat;
        old = {20'h11111, 20'h00042, 20'h33333, 20'h44444};
        preload(12'h005, old);
        run_cmd("read_write", 2'd2, 12'h005, 1'b0, 1'b1, 20'h80001, 0, e, r, lat);
        total++;
        if (r !== 20'h00042 || e !== old || lat !== 4) begin
            bad++;
            $display("FAIL read_write_directed: row=%h lat=%0d, required row=00042 lat=4", r, lat);
        end
        run_cmd("read_write_readback", 2'd0, 12'h005, 1'b0, 1'b1, 20'h0, 0, e, r, lat);
        total++;
        if (r !== 20'h80001 || e[79:60] !== old[79:60] || e[39:0] !== old[39:0]) begin
            bad++;
            $display("FAIL read_write_readback: entry=%h, required %h with dmem0=80001", e, old);
        end
    endtask

    task automatic test_backpressure();
        logic [ENT-1:0] e;  logic [ROW-1:0] r;  int lat;
        put_stall_fix = 4;  get_stall_fix = 3;
        run_cmd("backpressure", 2'd0, 12'h2A5, 1'b1, 1'b0, 20'h0, 5, e, r, lat);
        total++;
        if (lat !== 10) begin
            bad++;
            $display("FAIL backpressure_latency: got %0d, required 10", lat);
        end
        put_stall_fix = 0;  get_stall_fix = 0;
    endtask

    task automatic test_reset_mid_op();
        logic [ENT-1:0] e;  logic [ROW-1:0] r;  int lat;  int n;
        get_stall_fix = 1000;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        bus.cmd_valid = 1'b1;  bus.cmd_op = 2'd0;  bus.cmd_idx = 12'h0F0;
        bus.cmd_core_id = 1'b1;  bus.cmd_cache_type = 1'b0;
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.dir_get_valid !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        total++;
        if (bus.dir_get_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_reach_get: get_valid=%b, required 1", bus.dir_get_valid);
        end
        #2 RST = 1'b1;
        #1;
        total++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.dir_put_valid, bus.dir_get_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_async: {cmd_ready,rsp_valid,put_valid,get_valid}=%b, required 0000",
                     {bus.cmd_ready, bus.rsp_valid, bus.dir_put_valid, bus.dir_get_valid});
        end
        @(negedge CLK);
        #1 RST = 1'b0;
        get_stall_fix = 0;
        @(negedge CLK);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_entry !== '0) begin
            bad++;
            $display("FAIL reset_mid_release: cmd_ready=%b rsp_valid=%b, required 1 0",
                     bus.cmd_ready, bus.rsp_valid);
        end
        run_cmd("after_reset_read", 2'd0, 12'h0F0, 1'b1, 1'b0, 20'h0, 0, e, r, lat);
    endtask

    task automatic test_reserved_op();
        logic [ENT-1:0] e;  logic [ROW-1:0] r;  int lat;
        run_cmd("reserved_op", 2'd3, 12'h123, 1'b0, 1'b1, 20'hFFFFF, 0, e, r, lat);
        total++;
        if (last_rd_req[ROW+2] !== 1'b0 || r !== 20'h2) begin
            bad++;
            $display("FAIL reserved_as_read: write_valid=%b row=%h, required 0 00002",
                     last_rd_req[ROW+2], r);
        end
    endtask

    task automatic test_random();
        logic [ENT-1:0] e;  logic [ROW-1:0] r;  int lat;
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++)
            run_cmd("random", 2'($urandom_range(0, 3)), IW'($urandom_range(0, 7)),
                    1'($urandom()), 1'($urandom()), ROW'($urandom()),
                    int'($urandom_range(0, 3)), e, r, lat);
        rand_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [ENT-1:0] e;  logic [ROW-1:0] r;  int lat;
        for (int i = 0; i < 12; i++)
            run_cmd("back_to_back", 2'(i % 3), IW'(12'h300 + (i % 2)),
                    1'(i / 2), 1'(i / 3), ROW'($urandom()), 0, e, r, lat);
    endtask

    initial begin : main
        for (int i = 0; i < 4096; i++) begin
            dir_mem[i] = {$urandom(), $urandom(), 16'($urandom())};
            ref_mem[i] = dir_mem[i];
        end
        test_reset();
        test_read();
        test_write();
        test_read_write();
        test_backpressure();
        test_reset_mid_op();
        test_reserved_op();
        test_random();
        test_back_to_back();
        end_run();
    end

    initial begin : watchdog
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/bookkeeping_directory_client.md
Name: bookkeeping_directory_client

Overview:
Initiator-side controller for the bookkeeping directory's put/get interface. It accepts one coherence-bookkeeping command at a time from the protocol engine (READ, WRITE or READ_WRITE). It packs each command into the directory's put request and sequences the put/get handshakes. It captures the returned 4-row entry and delivers exactly one registered response per command, including the selected row for the requesting core/cache.

Parameters:
INDEX_WIDTH, 12, directory set-index width
TAG_WIDTH, 18, tag bits per row
MSI_STATE_SIZE, 2, MSI state bits per row (ROW = MSI_STATE_SIZE+TAG_WIDTH = 20; REQ = INDEX_WIDTH+1+ROW+2 = 35; ENTRY = 4*ROW = 80)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=READ, 1=WRITE, 2=READ_WRITE, 3=reserved (treated as READ)
cmd_idx  in  INDEX_WIDTH  set index
cmd_core_id  in  1  core 0/1
cmd_cache_type  in  1  0=imem, 1=dmem
cmd_row  in  ROW  new {state,tag} row for WRITE/READ_WRITE
rsp_valid  out  1  response held until rsp_ready
rsp_ready  in  1  consumer ready
rsp_entry  out  ENTRY  entry read {imem0,dmem0,imem1,dmem1}, MSB first; 0 for WRITE
rsp_row  out  ROW  row of rsp_entry selected by the command's core_id/cache_type; 0 for WRITE
dir_put_valid  out  1  to directory put_valid
dir_put_ready  in  1  from directory put_ready
dir_put_request  out  REQ  {idx, write_valid, row, core_id, cache_type}, MSB first
dir_get_valid  out  1  to directory get_valid
dir_get_ready  in  1  from directory get_ready
dir_get_response  in  ENTRY  from directory get_response

Behaviour:
- Reset (async on RST high): state=IDLE; cmd_ready=0 while RST=1, then 1 in IDLE. rsp_valid, dir_put_valid and dir_get_valid are 0. rsp_entry, rsp_row and the command register are 0.
- All outputs are driven from registers or state decode only. No combinational path from dir_put_ready or dir_get_ready to dir_put_valid or dir_get_valid, because the directory's put_ready depends on get_valid.
- FSM states: IDLE, PUT_RD, GET, PUT_WR, RSP.
- IDLE: cmd_ready=1. On accept, register op/idx/core/cache/row. WRITE goes to PUT_WR; READ, READ_WRITE and reserved go to PUT_RD.
- PUT_RD: dir_put_valid=1, write_valid=0, row field=0. On dir_put_ready, go to GET.
- GET: dir_get_valid=1. On dir_get_ready, capture dir_get_response into rsp_entry and the selected row into rsp_row.
  - Row selection by {core_id, cache_type}: 00 → [79:60], 01 → [59:40], 10 → [39:20], 11 → [19:0].
  - Next state: READ_WRITE goes to PUT_WR, otherwise RSP.
- PUT_WR: dir_put_valid=1, write_valid=1, row=cmd_row. On dir_put_ready, go to RSP. No get handshake is issued for writes.
- RSP: rsp_valid=1. On rsp_ready, go to IDLE. cmd_ready stays 0 in RSP; a new command is accepted no earlier than the cycle after the response handshake.
- Best-case latency (directory always ready, rsp_ready=1), counted from the accept edge:
  - READ: put at +1, get at +2, rsp_valid at +3.
  - WRITE: put at +1, rsp_valid at +2.
  - READ_WRITE: put at +1, get at +2, write put at +3, rsp_valid at +4.
- READ_WRITE response carries the pre-write entry. Only one directory transaction is in flight, so read-then-write is atomic with respect to this client.
- Stalls: request fields and valids stay stable while waiting for ready. Back-to-back commands to the same index need no hazard handling, because the directory commits a write before it can return a following read.
- Reset mid-operation returns to IDLE immediately. The in-flight command and response are dropped; the directory must be reset together.

Test Plan:
- READ idx=0x123, core=1, cache=1; directory entry = {20'h1,20'h2,20'h3,20'h4} → dir_put_request = {12'h123,1'b0,20'h0,1,1}; rsp_entry = that value; rsp_row = 20'h4; rsp_valid asserted 3 cycles after accept.
- WRITE idx=0x7FF, core=0, cache=0, row=20'hABCDE → one put with write_valid=1; no dir_get_valid; rsp_entry=0, rsp_row=0; a following READ of 0x7FF returns rsp_row=20'hABCDE.
- READ_WRITE idx=5, core=0, cache=1, row=20'h80001, old dmem0=20'h00042 → rsp_row=20'h00042; a following READ returns rsp_row=20'h80001; the other three rows are unchanged.
- Backpressure: hold dir_put_ready=0 for 4 cycles, then dir_get_ready=0 for 3, then rsp_ready=0 for 5 → request and valids are stable throughout, exactly one handshake each, cmd_ready=0 until the cycle after the response handshake.
- Assert RST in GET state → all valids drop asynchronously; after release cmd_ready=1 and the next READ completes normally.
- cmd_op=3 → behaves as READ (write_valid=0, full response).
